// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a FIFO feeds a registered serial line Tx.
// Optional even parity bit (8E1 frames) when UART_TX_PARITY_EN is defined.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous, active-low reset
//   wr_en      - push request, accepted when full=0
//   wr_data    - byte to push
//   full       - FIFO holds FIFO_SIZE bytes
//   fifo_count - bytes buffered, 0..FIFO_SIZE
//   busy       - a frame is in progress
//   frame_done - 1-cycle pulse after the final stop-bit cycle
//   Tx         - serial output, idle high
module uart_tx #(
  parameter int SYS_CLK_FREQ    = 100000000,
  parameter int UART_BAUD_RATE  = 115200,
  parameter int FIFO_SIZE       = 8,
  parameter int FIFO_INDEX_SIZE = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic [FIFO_INDEX_SIZE:0] fifo_count,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     Tx
);

  localparam int CLKS_PER_BIT = SYS_CLK_FREQ / UART_BAUD_RATE;
  localparam int CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = FIFO_INDEX_SIZE;
  localparam int CW = FIFO_INDEX_SIZE + 1;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       bit_nxt;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_end;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_SIZE];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          push;
  logic          pop;
  logic          have_data;
  logic [7:0]    head;

  assign push      = wr_en && !full_q;
  assign have_data = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign bit_end   = (cnt_q == CNT_LAST);
  assign bit_nxt   = bit_idx_q + 3'd1;

  // ---------------- FIFO ----------------

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_FULL);
  end

  // Storage has no reset: contents are only
  // observable through count/pointers, which do.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // ---------------- Framer FSM ----------------

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (have_data) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          tx_d      = shift_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^shift_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_nxt;
            tx_d      = shift_q[bit_nxt];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          cnt_d  = '0;
          done_d = 1'b1;
          // Chain straight into the next start
          // bit when more data is queued.
          if (have_data) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign Tx         = tx_q;
  assign frame_done = done_q;
  assign busy       = (state_q != S_IDLE);
  assign full       = full_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (CLKS_PER_BIT=16, 4-entry FIFO).
// Table-driven single frames, scoreboard frame monitor, corner sequences.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic [2:0] fifo_count;
  logic       busy;
  logic       frame_done;
  logic       Tx;

  uart_tx #(
    .SYS_CLK_FREQ   (16),
    .UART_BAUD_RATE (1),
    .FIFO_SIZE      (4),
    .FIFO_INDEX_SIZE(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .fifo_count(fifo_count),
    .busy      (busy),
    .frame_done(frame_done),
    .Tx        (Tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         starts[$];

  typedef struct {
    logic [7:0]    d;
    logic [NB-1:0] frame;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] frame_of(
    input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // Decodes every frame on Tx by mid-bit sampling
  // and compares against the scoreboard queue.
  task automatic monitor();
    bit            active = 0;
    int            mcnt = 0;
    logic [NB-1:0] bits = '0;
    logic [7:0]    e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active = 0;
        continue;
      end
      if (!active && Tx == 1'b0) begin
        active = 1;
        mcnt   = 0;
        starts.push_back(cyc);
      end
      if (active) begin
        if (mcnt % CPB == CPB / 2) begin
          bits[mcnt / CPB] = Tx;
          if (mcnt / CPB == NB - 1) begin
            active = 0;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL sb_frame: unexpected frame %0h",
                       bits);
            end else begin
              e = exp_q.pop_front();
              if (bits !== frame_of(e)) begin
                errors++;
                $display("FAIL sb_frame: got %0h, expected %0h",
                         bits, frame_of(e));
              end
            end
          end
        end
        mcnt++;
      end
    end
  endtask

  task automatic wait_drain(input string name,
                            input int budget,
                            output int ndone);
    int i;
    ndone = 0;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) ndone++;
      if (exp_q.size() == 0 && !busy) break;
    end
    repeat (2) begin
      @(negedge clk);
      if (frame_done) ndone++;
    end
    chk({name, "_drained"},
        {31'd0, (exp_q.size() == 0 && !busy)}, 1);
  endtask

  task automatic push1(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
  endtask

  initial begin
    int nd;
    int base;
    int dones[$];
    bit seen;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{d: 8'hA5, frame: 11'h54A};
    vecs[1] = '{d: 8'h07, frame: 11'h60E};
    vecs[2] = '{d: 8'h00, frame: 11'h400};
    vecs[3] = '{d: 8'hFF, frame: 11'h5FE};
`else
    vecs[0] = '{d: 8'hA5, frame: 10'h34A};
    vecs[1] = '{d: 8'h07, frame: 10'h20E};
    vecs[2] = '{d: 8'h00, frame: 10'h200};
    vecs[3] = '{d: 8'hFF, frame: 10'h3FE};
`endif

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", Tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_done", frame_done, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven single frames, cycle exact
    for (int v = 0; v < 4; v++) begin
      seen = 0;
      exp_q.push_back(vecs[v].d);
      push1(vecs[v].d);
      @(negedge clk);
      wr_en = 1'b0;
      chk("push_count", fifo_count, 1);
      @(negedge clk);
      chk("pop_tx", Tx, 0);
      chk("pop_busy", busy, 1);
      chk("pop_count", fifo_count, 0);
      for (int b = 0; b < NB; b++) begin
        for (int c = 0; c < CPB; c++) begin
          if (c == 0 || c == CPB - 1)
            chk("frame_bit", Tx, vecs[v].frame[b]);
          if (frame_done) seen = 1;
          @(negedge clk);
        end
      end
      chk("done_early", seen, 0);
      chk("done_pulse", frame_done, 1);
      chk("done_busy", busy, 0);
      chk("done_tx", Tx, 1);
      @(negedge clk);
      chk("done_width", frame_done, 0);
      repeat (3) @(negedge clk);
    end

    // Back-to-back frames
    base = starts.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    push1(8'h00);
    push1(8'hFF);
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 3 * FL; i++) begin
      @(negedge clk);
      if (frame_done) dones.push_back(cyc);
      if (dones.size() == 2) break;
    end
    chk("b2b_done_cnt", dones.size(), 2);
    if (dones.size() == 2)
      chk("b2b_done_gap", dones[1] - dones[0], FL);
    if (starts.size() >= base + 2)
      chk("b2b_start_gap",
          starts[base + 1] - starts[base], FL);
    else
      chk("b2b_starts", starts.size(), base + 2);
    wait_drain("b2b", 2 * FL, nd);

    // FIFO full: 0x06 must be dropped
    for (int i = 1; i <= 5; i++)
      exp_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++)
      push1(8'(i));
    @(negedge clk);
    wr_en = 1'b0;
    chk("full_flag", full, 1);
    chk("full_count", fifo_count, 4);
    wait_drain("full", 6 * FL, nd);
    chk("full_frames", nd, 5);

    // Push and pop at the STOP->START boundary
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    push1(8'h11);
    push1(8'h22);
    push1(8'h33);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (FL - 2) @(negedge clk);
    chk("bnd_pre_count", fifo_count, 2);
    wr_en   = 1'b1;
    wr_data = 8'h44;
    @(negedge clk);
    wr_en = 1'b0;
    chk("bnd_count", fifo_count, 2);
    chk("bnd_done", frame_done, 1);
    chk("bnd_tx", Tx, 0);
    chk("bnd_busy", busy, 1);
    wait_drain("bnd", 4 * FL, nd);
    chk("bnd_frames", nd, 3);

    // Reset in the middle of data bit 3
    push1(8'h00);
    push1(8'h81);
    push1(8'h82);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (4 * CPB + 4) @(negedge clk);
    chk("mid_count", fifo_count, 2);
    chk("mid_tx", Tx, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_tx", Tx, 1);
    chk("arst_count", fifo_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_full", full, 0);
    chk("arst_done", frame_done, 0);
    repeat (3) @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      @(negedge clk);
      if (Tx !== 1'b1 || busy || frame_done ||
          fifo_count != 0)
        seen = 1;
    end
    chk("quiet_after_rst", seen, 0);
    exp_q.push_back(8'h5A);
    push1(8'h5A);
    @(negedge clk);
    wr_en = 1'b0;
    wait_drain("post_rst", 2 * FL, nd);
    chk("post_rst_frames", nd, 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered 8-bit UART transmitter that drives the top-level `Tx` pin. It is the transmit counterpart of the `Rx` input at the top level. Software-side producers (core MMIO store path or bench) push bytes into an internal FIFO. The block serialises them as 8N1 frames, LSB first, at `UART_BAUD_RATE` derived from `SYS_CLK_FREQ`.

## Interface
Parameters:
- `SYS_CLK_FREQ`, 100000000: system clock frequency in Hz.
- `UART_BAUD_RATE`, 115200: line bit rate.
- `FIFO_SIZE`, 8: FIFO depth in bytes; must be a power of 2.
- `FIFO_INDEX_SIZE`, 3: log2(`FIFO_SIZE`).

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `wr_en`  in  1: push request.
- `wr_data`  in  8: byte to push.
- `full`  out  1: FIFO holds `FIFO_SIZE` bytes.
- `fifo_count`  out  `FIFO_INDEX_SIZE`+1: bytes currently buffered, 0..`FIFO_SIZE`.
- `busy`  out  1: a frame is in progress (state ≠ IDLE).
- `frame_done`  out  1: one-cycle pulse in the cycle after the final stop-bit cycle.
- `Tx`  out  1: serial line, registered, idle high.

## Operation
- `CLKS_PER_BIT` = `SYS_CLK_FREQ`/`UART_BAUD_RATE`, using integer division. A value below 1 is a configuration error.
- Bit counter: `CLKS_PER_BIT` cycles per bit, counting 0..`CLKS_PER_BIT`-1. It resets to 0 on every bit boundary.
- FIFO:
  - Circular buffer with write and read pointers of width `FIFO_INDEX_SIZE`. Pointers wrap naturally.
  - `fifo_count` tracks occupancy.
- Push: accepted at a posedge when `wr_en`=1 and `full`=0.
  - When `full`=1, the push is silently dropped, even if a pop happens in the same cycle.
- Pop: occurs on the IDLE→START (or STOP→START) transition. The popped byte is latched into an 8-bit shift register.
- Simultaneous accepted push and pop: `fifo_count` stays unchanged and both pointers advance.
- State machine:
  - IDLE: `Tx`=1. If `fifo_count`>0, pop and go to START.
  - START: `Tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `Tx`=shift[bit index] for `CLKS_PER_BIT` cycles. After index 7, go to PARITY (if enabled) or STOP; otherwise increment the index.
  - PARITY (macro only): `Tx`=even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `Tx`=1 for `CLKS_PER_BIT` cycles. At the end, assert `frame_done` next cycle. If `fifo_count`>0, pop and go to START (back-to-back, no idle gap); else go to IDLE.
- Reset (`rst`=0), at any time including mid-frame:
  - `Tx`=1, `busy`=0, `full`=0, `fifo_count`=0, `frame_done`=0.
  - State returns to IDLE, pointers and counters clear, and buffered bytes are discarded.

## Timing
- Push at edge N into an empty, idle block:
  - `fifo_count`=1 after edge N.
  - Pop at edge N+1: state=START, `Tx`=0, `busy`=1, `fifo_count`=0 after N+1.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity. Measured from the first `Tx`=0 cycle through the last stop cycle.
- `frame_done` is high for exactly 1 cycle, coincident with either the next START cycle or the first IDLE cycle.
- `full` and `fifo_count` are registered and reflect the state after the current edge. `full` = (`fifo_count`==`FIFO_SIZE`).
- Release of `rst`: the first state update occurs at the first posedge with `rst`=1.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in. Frames are 8E1, 11 bits.
- `UART_TX_PARITY_EN` undefined: the PARITY state is absent. Frames are 8N1, 10 bits. DATA goes directly to STOP.

## Test plan
Bench parameters: `SYS_CLK_FREQ`=16, `UART_BAUD_RATE`=1 (`CLKS_PER_BIT`=16), `FIFO_SIZE`=4, `FIFO_INDEX_SIZE`=2.
- Single byte: push 0xA5 when idle.
  - `Tx` is low 1 cycle after the push, for 16 cycles.
  - Then bits 1,0,1,0,0,1,0,1, 16 cycles each, then high for 16 cycles.
  - `frame_done` pulses at cycle 161 after the push. `busy` then drops.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles.
  - Two frames with no idle gap: the second start bit begins in the cycle immediately after the first stop bit ends.
  - `frame_done` pulses twice, 160 cycles apart.
- FIFO full: push 6 bytes 0x01..0x06 on consecutive cycles while idle.
  - The first is popped at once. 0x02..0x05 fill the FIFO and `full`=1.
  - 0x06 is dropped. Exactly 5 frames are observed: 0x01..0x05.
- Simultaneous push and pop at a STOP→START boundary with `fifo_count`=2: `fifo_count` stays 2, and byte ordering is preserved.
- Reset mid-frame: assert `rst`=0 during DATA bit 3 with 2 bytes buffered.
  - `Tx`=1 and `fifo_count`=0 immediately, without waiting for a clock edge.
  - After release, no frame is sent until a new push.
- `UART_TX_PARITY_EN` build: push 0x07.
  - Parity bit = 1 after data bit 7. The frame is 176 cycles, and `frame_done` pulses at cycle 177.
